// File: rtl/multi_cycle_controller.sv
// Main control FSM for the multicycle RV32I core. Sequences one instruction
// through 3-5 states and drives every mux select and write strobe of the
// shared datapath. It stalls on the unified-memory ready handshake and keeps
// a count of retired instructions.
module multi_cycle_controller #(
  parameter int COUNT_W         = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_srst,
  input  logic [6:0]         i_opcode,
  input  logic [2:0]         i_funct3,
  input  logic               i_funct7b5,
  input  logic               i_zero,
  input  logic               i_memReady,
  output logic               o_pcWrite,
  output logic               o_adrSrc,
  output logic               o_memWrite,
  output logic               o_irWrite,
  output logic               o_regWrite,
  output logic [1:0]         o_resultSrc,
  output logic [1:0]         o_aluSrcA,
  output logic [1:0]         o_aluSrcB,
  output logic [1:0]         o_immSrc,
  output logic [2:0]         o_aluControl,
  output logic               o_illegal,
  output logic [3:0]         o_state,
  output logic [COUNT_W-1:0] o_retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t               r_state;
  logic [COUNT_W-1:0]   r_retired;

  state_t               w_next;
  state_t               w_bad;
  logic                 w_retire;
  logic                 w_funct3_ok;
  logic [2:0]           w_alu_dec;
  logic                 w_pc_update;
  logic                 w_branch;

  assign w_funct3_ok = i_funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
  // An illegal instruction either parks the core or is silently skipped.
  assign w_bad       = HALT_ON_ILLEGAL ? S_ERROR : S_FETCH;

  // Next-state selection and retire detection.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next   = S_FETCH;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:    w_next = i_memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = w_funct3_ok ? S_EXECR : w_bad;
          OP_I:         w_next = w_funct3_ok ? S_EXECI : w_bad;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = w_bad;
        endcase
      end
      S_MEMADR:   w_next = i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = i_memReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEMWRITE: begin
        w_next   = i_memReady ? S_FETCH : S_MEMWRITE;
        w_retire = i_memReady;
      end
      S_EXECR, S_EXECI: w_next = S_ALUWB;
      S_ALUWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_JAL:      w_next = S_ALUWB;
      S_BEQ: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_ERROR:    w_next = S_ERROR;
      default:    w_next = S_FETCH;
    endcase
  end

  // ALU operation for register and immediate arithmetic; bit 30 selects sub
  // only for R-type, since in I-type it is part of the immediate.
  always_comb begin
    w_alu_dec = 3'b000;
    case (i_funct3)
      3'b000:  w_alu_dec = (i_opcode[5] & i_funct7b5) ? 3'b001 : 3'b000;
      3'b010:  w_alu_dec = 3'b101;
      3'b110:  w_alu_dec = 3'b011;
      3'b111:  w_alu_dec = 3'b010;
      default: w_alu_dec = 3'b000;
    endcase
  end

  // State-decoded datapath controls; reset forces the FETCH view with all
  // write strobes low.
  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    o_adrSrc     = 1'b0;
    o_memWrite   = 1'b0;
    o_irWrite    = 1'b0;
    o_regWrite   = 1'b0;
    o_resultSrc  = 2'b00;
    o_aluSrcA    = 2'b00;
    o_aluSrcB    = 2'b00;
    o_aluControl = 3'b000;
    o_illegal    = 1'b0;
    o_state      = r_state;
    case (i_opcode)
      OP_SW:   o_immSrc = 2'b01;
      OP_BEQ:  o_immSrc = 2'b10;
      OP_JAL:  o_immSrc = 2'b11;
      default: o_immSrc = 2'b00;
    endcase
    case (r_state)
      S_FETCH: begin
        o_aluSrcB   = 2'b10;
        o_resultSrc = 2'b10;
        o_irWrite   = i_memReady;
        w_pc_update = i_memReady;
      end
      S_DECODE: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b01;
      end
      S_MEMADR: begin
        o_aluSrcA = 2'b10;
        o_aluSrcB = 2'b01;
      end
      S_MEMREAD:  o_adrSrc = 1'b1;
      S_MEMWB: begin
        o_resultSrc = 2'b01;
        o_regWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        o_adrSrc   = 1'b1;
        o_memWrite = 1'b1;
      end
      S_EXECR: begin
        o_aluSrcA    = 2'b10;
        o_aluControl = w_alu_dec;
      end
      S_EXECI: begin
        o_aluSrcA    = 2'b10;
        o_aluSrcB    = 2'b01;
        o_aluControl = w_alu_dec;
      end
      S_ALUWB:    o_regWrite = 1'b1;
      S_JAL: begin
        o_aluSrcA   = 2'b01;
        o_aluSrcB   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        o_aluSrcA    = 2'b10;
        o_aluControl = 3'b001;
        w_branch     = 1'b1;
      end
      S_ERROR:    o_illegal = 1'b1;
      default:    ;
    endcase
    o_pcWrite = w_pc_update | (w_branch & i_zero);
    if (i_srst) begin
      o_pcWrite    = 1'b0;
      o_adrSrc     = 1'b0;
      o_memWrite   = 1'b0;
      o_irWrite    = 1'b0;
      o_regWrite   = 1'b0;
      o_resultSrc  = 2'b10;
      o_aluSrcA    = 2'b00;
      o_aluSrcB    = 2'b10;
      o_immSrc     = 2'b00;
      o_aluControl = 3'b000;
      o_illegal    = 1'b0;
      o_state      = S_FETCH;
    end
  end

  // State register and retired-instruction counter; reset wins over retire.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_srst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + COUNT_W'(1);
    end
  end

  assign o_retired = r_retired;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: decode table, hand-written
// handshake/reset/error sequences, and random instruction streams checked
// against an instruction-level reference model.
module tb_multi_cycle_controller;

  logic        i_clk = 1'b0;
  logic        i_srst;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic        i_funct7b5;
  logic        i_zero;
  logic        i_memReady;
  logic        o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite;
  logic [1:0]  o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc;
  logic [2:0]  o_aluControl;
  logic        o_illegal;
  logic [3:0]  o_state;
  logic [31:0] o_retired;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_ret;

  multi_cycle_controller #(.COUNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .i_clk(i_clk), .i_srst(i_srst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_memReady(i_memReady),
    .o_pcWrite(o_pcWrite), .o_adrSrc(o_adrSrc), .o_memWrite(o_memWrite),
    .o_irWrite(o_irWrite), .o_regWrite(o_regWrite), .o_resultSrc(o_resultSrc),
    .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_immSrc(o_immSrc),
    .o_aluControl(o_aluControl), .o_illegal(o_illegal), .o_state(o_state),
    .o_retired(o_retired)
  );

  always #5 i_clk = ~i_clk;

  // Phase numbers as published for the debug state port.
  localparam logic [3:0] P_F = 4'd0, P_D = 4'd1, P_MA = 4'd2, P_MR = 4'd3,
                         P_MW = 4'd4, P_MWR = 4'd5, P_ER = 4'd6, P_AW = 4'd7,
                         P_EI = 4'd8, P_J = 4'd9, P_B = 4'd10, P_ERR = 4'd11;

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic [3:0] exp_state;
    logic [2:0] exp_alu;
    logic [1:0] exp_imm;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_srst     = 1'b1;
    i_memReady = 1'b1;
    tick();
    i_srst = 1'b0;
  endtask

  // Fetch/decode a table entry and inspect the state it dispatches to.
  task automatic run_table();
    vec_t tbl[13];
    tbl[0]  = '{7'b0110011, 3'b000, 1'b0, P_ER,  3'b000, 2'b00};
    tbl[1]  = '{7'b0110011, 3'b000, 1'b1, P_ER,  3'b001, 2'b00};
    tbl[2]  = '{7'b0110011, 3'b010, 1'b0, P_ER,  3'b101, 2'b00};
    tbl[3]  = '{7'b0110011, 3'b110, 1'b0, P_ER,  3'b011, 2'b00};
    tbl[4]  = '{7'b0110011, 3'b111, 1'b1, P_ER,  3'b010, 2'b00};
    tbl[5]  = '{7'b0010011, 3'b000, 1'b1, P_EI,  3'b000, 2'b00};
    tbl[6]  = '{7'b0010011, 3'b010, 1'b0, P_EI,  3'b101, 2'b00};
    tbl[7]  = '{7'b0110011, 3'b001, 1'b0, P_ERR, 3'b000, 2'b00};
    tbl[8]  = '{7'b0000011, 3'b010, 1'b0, P_MA,  3'b000, 2'b00};
    tbl[9]  = '{7'b0100011, 3'b010, 1'b0, P_MA,  3'b000, 2'b01};
    tbl[10] = '{7'b1101111, 3'b000, 1'b0, P_J,   3'b000, 2'b11};
    tbl[11] = '{7'b1100011, 3'b000, 1'b0, P_B,   3'b001, 2'b10};
    tbl[12] = '{7'b1111111, 3'b000, 1'b0, P_ERR, 3'b000, 2'b00};
    for (int i = 0; i < 13; i++) begin
      do_reset();
      i_opcode = tbl[i].opcode; i_funct3 = tbl[i].funct3; i_funct7b5 = tbl[i].f7b5;
      i_memReady = 1'b1; i_zero = 1'b0;
      tick(); tick();
      #2;
      check($sformatf("tbl%0d state", i), 32'(o_state), 32'(tbl[i].exp_state));
      check($sformatf("tbl%0d alu", i), 32'(o_aluControl), 32'(tbl[i].exp_alu));
      check($sformatf("tbl%0d imm", i), 32'(o_immSrc), 32'(tbl[i].exp_imm));
      check($sformatf("tbl%0d illegal", i), 32'(o_illegal), 32'(tbl[i].exp_state == P_ERR));
    end
  endtask

  // Random instruction stream. The model knows each instruction's phase path,
  // which phases wait on memory, what strobes each phase must raise and when
  // an instruction counts as retired.
  task automatic run_random(input int n_instr);
    logic [3:0] path[$];
    int         m, stalls;
    logic       rdy, z, waits, retires;
    logic [2:0] exp_alu;
    logic [1:0] exp_imm;
    logic [3:0] p;
    for (int n = 0; n < n_instr; n++) begin
      m = $urandom_range(0, 12);
      i_funct7b5 = 1'($urandom_range(0, 1));
      i_funct3   = 3'($urandom_range(0, 7));
      exp_alu = 3'b000; exp_imm = 2'b00;
      case (m)
        0:  begin i_opcode = 7'b0000011; path = '{P_F, P_D, P_MA, P_MR, P_MW}; end
        1:  begin i_opcode = 7'b0100011; exp_imm = 2'b01; path = '{P_F, P_D, P_MA, P_MWR}; end
        2:  begin i_opcode = 7'b0110011; i_funct3 = 3'b000; i_funct7b5 = 1'b0; end
        3:  begin i_opcode = 7'b0110011; i_funct3 = 3'b000; i_funct7b5 = 1'b1; exp_alu = 3'b001; end
        4:  begin i_opcode = 7'b0110011; i_funct3 = 3'b010; exp_alu = 3'b101; end
        5:  begin i_opcode = 7'b0110011; i_funct3 = 3'b110; exp_alu = 3'b011; end
        6:  begin i_opcode = 7'b0110011; i_funct3 = 3'b111; exp_alu = 3'b010; end
        7:  begin i_opcode = 7'b0010011; i_funct3 = 3'b000; end
        8:  begin i_opcode = 7'b0010011; i_funct3 = 3'b010; exp_alu = 3'b101; end
        9:  begin i_opcode = 7'b0010011; i_funct3 = 3'b110; exp_alu = 3'b011; end
        10: begin i_opcode = 7'b0010011; i_funct3 = 3'b111; exp_alu = 3'b010; end
        11: begin i_opcode = 7'b1101111; exp_imm = 2'b11; path = '{P_F, P_D, P_J, P_AW}; end
        default: begin i_opcode = 7'b1100011; exp_imm = 2'b10; path = '{P_F, P_D, P_B}; end
      endcase
      if (m >= 2 && m <= 6)  path = '{P_F, P_D, P_ER, P_AW};
      if (m >= 7 && m <= 10) path = '{P_F, P_D, P_EI, P_AW};
      foreach (path[k]) begin
        p = path[k];
        waits = (p == P_F) || (p == P_MR) || (p == P_MWR);
        stalls = 0;
        do begin
          rdy = waits ? ((stalls >= 4) || ($urandom_range(0, 3) != 0)) : 1'($urandom_range(0, 1));
          z   = 1'($urandom_range(0, 1));
          i_memReady = rdy; i_zero = z;
          #2;
          check("rnd state", 32'(o_state), 32'(p));
          check("rnd pcWrite", 32'(o_pcWrite), 32'((p == P_F && rdy) || p == P_J || (p == P_B && z)));
          check("rnd irWrite", 32'(o_irWrite), 32'(p == P_F && rdy));
          check("rnd regWrite", 32'(o_regWrite), 32'(p == P_MW || p == P_AW));
          check("rnd memWrite", 32'(o_memWrite), 32'(p == P_MWR));
          check("rnd immSrc", 32'(o_immSrc), 32'(exp_imm));
          check("rnd retired", o_retired, 32'(exp_ret));
          if (p == P_ER || p == P_EI) check("rnd aluControl", 32'(o_aluControl), 32'(exp_alu));
          retires = (p == P_MW) || (p == P_AW) || (p == P_B) || (p == P_MWR && rdy);
          tick();
          if (retires) exp_ret++;
          stalls++;
        end while (waits && !rdy);
      end
    end
    #2;
    check("rnd final state", 32'(o_state), 32'(P_F));
    check("rnd final retired", o_retired, 32'(exp_ret));
  endtask

  initial begin
    logic [3:0] lw_trace[5];
    lw_trace = '{P_F, P_D, P_MA, P_MR, P_MW};
    i_srst = 1'b1; i_memReady = 1'b1; i_zero = 1'b0;
    i_opcode = 7'b0000011; i_funct3 = 3'b010; i_funct7b5 = 1'b0;

    // Reset held three cycles with memory ready.
    for (int c = 0; c < 3; c++) begin
      #2;
      check("rst state", 32'(o_state), 32'(P_F));
      check("rst strobes", {28'd0, o_pcWrite, o_irWrite, o_regWrite, o_memWrite}, 32'd0);
      check("rst aluSrcB", 32'(o_aluSrcB), 32'd2);
      tick();
    end
    check("rst retired", o_retired, 32'd0);
    i_srst = 1'b0;
    #2;
    check("first fetch irWrite", 32'(o_irWrite), 32'd1);
    check("first fetch pcWrite", 32'(o_pcWrite), 32'd1);
    tick();
    #2;
    check("decode irWrite", 32'(o_irWrite), 32'd0);
    check("decode pcWrite", 32'(o_pcWrite), 32'd0);

    // lw with ready always high.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #2;
      check("lw trace", 32'(o_state), 32'(lw_trace[c]));
      check("lw regWrite", 32'(o_regWrite), 32'(c == 4));
      if (c == 4) check("lw resultSrc", 32'(o_resultSrc), 32'd1);
      tick();
    end
    #2;
    check("lw back to fetch", 32'(o_state), 32'(P_F));
    check("lw retired", o_retired, 32'd1);

    // sw with two stall cycles in MEMWRITE.
    i_opcode = 7'b0100011;
    tick(); tick(); tick();
    for (int c = 0; c < 3; c++) begin
      i_memReady = (c == 2);
      #2;
      check("sw state", 32'(o_state), 32'(P_MWR));
      check("sw memWrite", 32'(o_memWrite), 32'd1);
      check("sw adrSrc", 32'(o_adrSrc), 32'd1);
      check("sw immSrc", 32'(o_immSrc), 32'd1);
      check("sw retired hold", o_retired, 32'd1);
      tick();
    end
    #2;
    check("sw back to fetch", 32'(o_state), 32'(P_F));
    check("sw retired", o_retired, 32'd2);

    run_table();

    // Illegal opcode parks in ERROR regardless of memory activity.
    do_reset();
    i_opcode = 7'b1111111;
    tick(); tick();
    for (int c = 0; c < 10; c++) begin
      i_memReady = 1'($urandom_range(0, 1)); i_zero = 1'($urandom_range(0, 1));
      #2;
      check("err state", 32'(o_state), 32'(P_ERR));
      check("err illegal", 32'(o_illegal), 32'd1);
      check("err strobes", {28'd0, o_pcWrite, o_irWrite, o_regWrite, o_memWrite}, 32'd0);
      tick();
    end

    // Reset in the middle of a stalled load clears state and count.
    do_reset();
    i_opcode = 7'b0000011;
    for (int c = 0; c < 5; c++) tick();
    tick(); tick(); tick();
    i_memReady = 1'b0;
    #2;
    check("mid state", 32'(o_state), 32'(P_MR));
    check("mid retired", o_retired, 32'd1);
    i_srst = 1'b1;
    tick();
    i_srst = 1'b0; i_memReady = 1'b0;
    #2;
    check("mid rst state", 32'(o_state), 32'(P_F));
    check("mid rst retired", o_retired, 32'd0);

    do_reset();
    exp_ret = 0;
    run_random(80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
